// File: rtl/game_countdown.sv
// BCD seconds countdown for timed game modes; flags expiry to the game FSM.
// Define GAME_COUNTDOWN_BONUS_EN to add the bonus port and BCD adder.
module game_countdown #(
    parameter int          CLOCK_HZ  = 65_000_000,
    parameter logic [27:0] BONUS_BCD = 28'h000_0010
) (
    input  logic        system_clock_in,
    input  logic        system_reset_n_in,
    input  logic        load,
    input  logic [27:0] load_value_bcd,
    input  logic        playing,
`ifdef GAME_COUNTDOWN_BONUS_EN
    input  logic        bonus,
`endif
    output logic [27:0] remaining_bcd,
    output logic        running,
    output logic        expired,
    output logic        expire_pulse
);

    localparam int PW = (CLOCK_HZ > 1) ? $clog2(CLOCK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLOCK_HZ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUNNING,
        S_PAUSED,
        S_EXPIRED
    } state_t;

    state_t        state_q, state_d;
    logic [27:0]   value_q, value_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          pulse_q, pulse_d;
    logic          tick;
    logic [27:0]   stepped;
    logic [27:0]   summed;

    function automatic logic [27:0] bcd_clamp(input logic [27:0] v);
        logic [27:0] r;
        r = v;
        for (int i = 0; i < 7; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Digit-serial decrement: zeros roll to 9 and keep borrowing
    function automatic logic [27:0] bcd_dec(input logic [27:0] v);
        logic [27:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

`ifdef GAME_COUNTDOWN_BONUS_EN
    function automatic logic [27:0] bcd_add(input logic [27:0] a,
                                            input logic [27:0] b);
        logic [27:0] r;
        logic [4:0]  s;
        logic        c;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
            if (s > 5'd9) begin
                s           = s - 5'd10;
                r[4*i +: 4] = s[3:0];
                c           = 1'b1;
            end else begin
                r[4*i +: 4] = s[3:0];
                c           = 1'b0;
            end
        end
        return c ? 28'h999_9999 : r;
    endfunction
`endif

    assign tick    = (state_q == S_RUNNING) && (presc_q == PRESC_MAX);
    assign stepped = tick ? bcd_dec(value_q) : value_q;

`ifdef GAME_COUNTDOWN_BONUS_EN
    assign summed = (bonus && state_q != S_EXPIRED)
                  ? bcd_add(stepped, BONUS_BCD) : stepped;
`else
    assign summed = stepped;
`endif

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        presc_d = presc_q;
        pulse_d = 1'b0;
        if (load) begin
            state_d = S_IDLE;
            value_d = bcd_clamp(load_value_bcd);
            presc_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    value_d = summed;
                    if (playing && value_q != 28'd0) state_d = S_RUNNING;
                end
                S_RUNNING: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    value_d = summed;
                    if (tick && summed == 28'd0) begin
                        state_d = S_EXPIRED;
                        pulse_d = 1'b1;
                    end else if (!playing) begin
                        state_d = S_PAUSED;
                    end
                end
                S_PAUSED: begin
                    value_d = summed;
                    if (playing) state_d = S_RUNNING;
                end
                S_EXPIRED: begin
                    value_d = value_q;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge system_clock_in or negedge system_reset_n_in) begin
        if (!system_reset_n_in) begin
            state_q <= S_IDLE;
            value_q <= '0;
            presc_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            presc_q <= presc_d;
            pulse_q <= pulse_d;
        end
    end

    assign remaining_bcd = value_q;
    assign running       = (state_q == S_RUNNING);
    assign expired       = (state_q == S_EXPIRED);
    assign expire_pulse  = pulse_q;

endmodule

// File: tb/tb_game_countdown.sv
// Scoreboarded random + directed bench for game_countdown.
module tb_game_countdown;

    localparam int          HZ   = 4;
    localparam logic [27:0] BON  = 28'h000_0010;
    localparam int          MAXV = 9_999_999;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [27:0] lval = '0;
    logic        playing = 1'b0;
    logic        bonus = 1'b0;
    logic [27:0] rem;
    logic        running, expired, expire_pulse;

    typedef struct packed {
        logic [27:0] v;
        logic        run;
        logic        exp;
        logic        pls;
    } obs_t;

    obs_t q[$];
    int   total = 0;
    int   bad = 0;

    int   m_val = 0;
    int   m_mode = M_IDLE;
    int   m_phase = 0;
    bit   m_pulse = 1'b0;

    always #5 clk = ~clk;

    game_countdown #(.CLOCK_HZ(HZ), .BONUS_BCD(BON)) dut (
        .system_clock_in   (clk),
        .system_reset_n_in (rst_n),
        .load              (load),
        .load_value_bcd    (lval),
        .playing           (playing),
`ifdef GAME_COUNTDOWN_BONUS_EN
        .bonus             (bonus),
`endif
        .remaining_bcd     (rem),
        .running           (running),
        .expired           (expired),
        .expire_pulse      (expire_pulse)
    );

    function automatic int from_bcd(logic [27:0] b);
        int r = 0;
        int w = 1;
        int d;
        for (int i = 0; i < 7; i++) begin
            d = int'(b[4*i +: 4]);
            if (d > 9) d = 9;
            r += d * w;
            w *= 10;
        end
        return r;
    endfunction

    function automatic logic [27:0] to_bcd(int v);
        logic [27:0] r = '0;
        for (int i = 0; i < 7; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int sat_add(int a);
        int s = a + from_bcd(BON);
        return (s > MAXV) ? MAXV : s;
    endfunction

    function automatic void chk(string nm, obs_t got, obs_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got v=%h run=%b exp=%b pls=%b want v=%h run=%b exp=%b pls=%b",
                     nm, got.v, got.run, got.exp, got.pls,
                     want.v, want.run, want.exp, want.pls);
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.v   = to_bcd(m_val);
        o.run = (m_mode == M_RUN);
        o.exp = (m_mode == M_EXP);
        o.pls = m_pulse;
        return o;
    endfunction

    // Reference behaviour in whole seconds; one call per clock edge
    task automatic model_step(bit rs, bit ld, logic [27:0] lv, bit pl, bit bn);
        int nv;
        bit tk;
        m_pulse = 1'b0;
        if (rs) begin
            m_val = 0; m_mode = M_IDLE; m_phase = 0;
        end else if (ld) begin
            m_val = from_bcd(lv); m_mode = M_IDLE; m_phase = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    nv = bn ? sat_add(m_val) : m_val;
                    if (pl && m_val != 0) m_mode = M_RUN;
                    m_val = nv;
                end
                M_RUN: begin
                    tk = (m_phase == HZ - 1);
                    m_phase = tk ? 0 : m_phase + 1;
                    nv = tk ? m_val - 1 : m_val;
                    if (bn) nv = sat_add(nv);
                    m_val = nv;
                    if (tk && nv == 0) begin
                        m_mode = M_EXP; m_pulse = 1'b1;
                    end else if (!pl) begin
                        m_mode = M_PAUSE;
                    end
                end
                M_PAUSE: begin
                    if (bn) m_val = sat_add(m_val);
                    if (pl) m_mode = M_RUN;
                end
                default: ;
            endcase
        end
    endtask

    task automatic step(bit rs, bit ld, logic [27:0] lv, bit pl, bit bn);
        @(negedge clk);
        rst_n   = !rs;
        load    = ld;
        lval    = lv;
        playing = pl;
        bonus   = bn;
        model_step(rs, ld, lv, pl, bn);
        q.push_back(model_obs());
    endtask

    task automatic run(int n, bit pl);
        repeat (n) step(1'b0, 1'b0, 28'd0, pl, 1'b0);
    endtask

    task automatic ld(logic [27:0] v);
        step(1'b0, 1'b1, v, 1'b0, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            obs_t e;
            e = q.pop_front();
            chk("cycle", {rem, running, expired, expire_pulse}, e);
        end
    end

    initial begin
        obs_t zero;
        zero = '0;
        #1;
        chk("reset_async", {rem, running, expired, expire_pulse}, zero);
        step(1'b1, 1'b0, 28'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 28'd0, 1'b1, 1'b0);

        ld(28'h000_0012); run(14, 1'b1);
        ld(28'h000_0100); run(6, 1'b1);
        ld(28'h000_0002); run(14, 1'b1);
        // pause mid-prescale, then resume
        ld(28'h000_0012); run(3, 1'b1); run(10, 1'b0); run(6, 1'b1);
        ld(28'h000_0012); run(3, 1'b1); ld(28'h00A_0005); run(2, 1'b0);
        // load on the tick cycle
        ld(28'h000_0012); run(4, 1'b1); ld(28'h000_0345); run(2, 1'b0);
        // playing drops on the tick cycle
        ld(28'h000_0012); run(4, 1'b1); run(3, 1'b0);
        // reset mid-count
        ld(28'h000_0012); run(3, 1'b1);
        step(1'b1, 1'b0, 28'd0, 1'b1, 1'b0);
        #1;
        chk("reset_mid", {rem, running, expired, expire_pulse}, zero);
        step(1'b1, 1'b0, 28'd0, 1'b1, 1'b0);
        run(6, 1'b1);

`ifdef GAME_COUNTDOWN_BONUS_EN
        ld(28'h000_0095); step(1'b0, 1'b0, 28'd0, 1'b0, 1'b1); run(1, 1'b0);
        ld(28'h999_9995); step(1'b0, 1'b0, 28'd0, 1'b0, 1'b1); run(1, 1'b0);
        ld(28'h000_0001); run(4, 1'b1);
        step(1'b0, 1'b0, 28'd0, 1'b1, 1'b1); run(6, 1'b1);
`endif

        begin
            bit pl = 1'b0;
            bit bn;
            logic [27:0] v;
            for (int i = 0; i < 3000; i++) begin
                bn = 1'b0;
`ifdef GAME_COUNTDOWN_BONUS_EN
                bn = ($urandom_range(0, 19) == 0);
`endif
                if ($urandom_range(0, 7) == 0) pl = !pl;
                if ($urandom_range(0, 39) == 0) begin
                    if ($urandom_range(0, 4) == 0) v = 28'($urandom);
                    else v = to_bcd(int'($urandom_range(0, 40)));
                    step(1'b0, 1'b1, v, pl, bn);
                end else begin
                    step(1'b0, 1'b0, 28'd0, pl, bn);
                end
            end
        end

        @(posedge clk);
        #3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_countdown.md
# game_countdown

BCD countdown timer for time-limited game modes; the down-counting counterpart of the game timer. Loads a 7-digit BCD seconds value, decrements it once per second while the game is playing, and flags expiry to the game FSM. `remaining_bcd` uses the same packed BCD format the 8-digit hex display consumes, so it can drive that display directly.

## Interface
- `CLOCK_HZ`, default 65_000_000: clock cycles per one-second tick.
- `BONUS_BCD`, default 28'h000_0010: packed BCD seconds added on a bonus event.
- `system_clock_in` input 1: system clock.
- `system_reset_n_in` input 1: reset, asynchronous and active-low.
- `load` input 1: one-cycle pulse; captures `load_value_bcd`.
- `load_value_bcd` input 28: 7-digit packed BCD start value; digit i is bits [4i+3:4i].
- `playing` input 1: level; the countdown runs while this is high.
- `bonus` input 1: one-cycle pulse; adds `BONUS_BCD`. Present only when bonus support is compiled in (see Configuration).
- `remaining_bcd` output 28: registered remaining time, packed BCD.
- `running` output 1: high in RUNNING.
- `expired` output 1: level, high in EXPIRED.
- `expire_pulse` output 1: one-cycle pulse on entry to EXPIRED.

## Operation
- States:
  - IDLE: holds the value.
  - RUNNING: prescaler counts.
  - PAUSED: prescaler frozen at its current value.
  - EXPIRED: terminal until the next `load`.
- Transitions:
  - IDLE→RUNNING when `playing` and `remaining_bcd != 0`.
  - RUNNING→PAUSED when `!playing`.
  - PAUSED→RUNNING when `playing`.
  - RUNNING→EXPIRED when a tick decrements the value to 0.
  - In IDLE with value 0, the block stays in IDLE regardless of `playing`.
- `load` has highest priority:
  - From any state, go to IDLE.
  - `remaining_bcd` takes `load_value_bcd`; prescaler clears to 0.
  - `expired` drops.
  - Any load digit >9 is clamped to 9.
- Prescaler:
  - Counts 0..CLOCK_HZ-1 in RUNNING.
  - Tick fires on the cycle it equals CLOCK_HZ-1; it wraps to 0 on that cycle.
  - Tick period is exactly CLOCK_HZ cycles.
- BCD decrement:
  - Digit 0 becomes 9 and borrows from the next digit.
  - Non-zero digit decrements by 1 with no borrow.
  - Never applied at value 0; no wrap to 9999999.
- All digits of `remaining_bcd` are always valid BCD (0–9).

## Timing
- Reset values:
  - State IDLE.
  - `remaining_bcd` = 0, prescaler = 0.
  - `running` = 0, `expired` = 0, `expire_pulse` = 0.
- `load` is visible on `remaining_bcd` one cycle after the pulse.
- On a tick cycle, the new value appears the next cycle.
- When the decrement reaches 0, on that same edge:
  - `expired` is set and `expire_pulse` is asserted.
  - `running` drops.
- `expire_pulse` lasts exactly one cycle and is never reasserted without an intervening `load`.
- `playing` falling on the tick cycle: the tick still applies, then the block enters PAUSED.
- `load` and tick on the same cycle: the load wins and the tick is discarded.
- Reset asserted mid-count: all state clears immediately; there is no pending tick after release.

## Configuration
- `GAME_COUNTDOWN_BONUS_EN` defined:
  - The `bonus` port exists.
  - In IDLE, RUNNING or PAUSED, `bonus` adds `BONUS_BCD` with decimal carry per digit.
  - The sum saturates at 28'h999_9999.
  - Same cycle as a tick: result = (value−1)+BONUS_BCD, and no expiry occurs if that result is non-zero.
  - Ignored in EXPIRED and when `load` is asserted.
  - Prescaler unaffected.
- `GAME_COUNTDOWN_BONUS_EN` undefined:
  - No `bonus` port and no adder logic.
  - All other behaviour is identical.

## Test plan
- Reset, CLOCK_HZ=4, load 28'h0000_012, hold `playing`:
  - Values 12→11→10→09 appear every 4 cycles.
  - `running` is high throughout.
- Load 28'h0000_100, run one tick:
  - Result is 28'h0000_099 (multi-digit borrow).
- Load 28'h0000_002, run to expiry:
  - Value reaches 0 after 8 cycles of `playing`.
  - `expired` = 1; `expire_pulse` is high exactly 1 cycle.
  - Further cycles leave value 0 with no pulse.
- Drop `playing` mid-prescale (2 of 4 cycles elapsed), hold low 10 cycles, raise again:
  - Value unchanged while low.
  - Next tick arrives 2 cycles after resume.
- Load 28'h00A_0005 while RUNNING:
  - Result is 28'h009_0005 next cycle, state IDLE, prescaler 0.
  - Repeat with `load` coincident with a tick: load value wins.
- With `GAME_COUNTDOWN_BONUS_EN` and BONUS_BCD=0x10:
  - Bonus at 0x95 gives 0x105.
  - Bonus at 28'h999_9995 gives 28'h999_9999.
  - Bonus coincident with a tick at 0x01 gives 0x10 and no `expire_pulse`.
